sap1_control_sequencer: RTL

//  Control/sequencer unit for the SAP-1 datapath: a 6-state ring counter (T1..T6) plus instruction decode.

---
 rtl/sap1_pkg.sv | 55 +++++
 rtl/sap1_ring_counter.sv | 31 +++
 rtl/sap1_control_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared types for the SAP-1 control sequencer: opcodes, T-states and the
// packed control word carrying the twelve datapath strobes.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd6
    } tstate_e;

    typedef struct packed {
        logic pc_inc;
        logic pc_en;
        logic mar_ld;
        logic ram_en;
        logic ir_ld;
        logic ir_en;
        logic acc_ld;
        logic acc_en;
        logic su;
        logic eu;
        logic b_ld;
        logic out_ld;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = 12'h000;

    // Map the one-hot ring counter value onto a T-state; all-zero is HALT.
    function automatic tstate_e onehot_to_tstate(input logic [5:0] oh);
        tstate_e ts;
        case (oh)
            6'b000001: ts = T1;
            6'b000010: ts = T2;
            6'b000100: ts = T3;
            6'b001000: ts = T4;
            6'b010000: ts = T5;
            6'b100000: ts = T6;
            default:   ts = HALT;
        endcase
        return ts;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-position one-hot ring counter (bit0 = T1). A halt request parks it at
// all-zero, which it never leaves until clr_n; skip returns it to T1 early.
module sap1_ring_counter (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       adv,
    input  logic       skip,
    input  logic       halt,
    output logic [5:0] state
);

    logic [5:0] r_state;

    // Step the ring on each enabled edge; all-zero stays all-zero when rotated.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= 6'b000001;
        end else if (adv) begin
            if (halt) begin
                r_state <= 6'b000000;
            end else if (skip) begin
                r_state <= 6'b000001;
            end else begin
                r_state <= {r_state[4:0], r_state[5]};
            end
        end
    end

    assign state = r_state;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring counter plus instruction decode that
// drives the datapath bus-enable and load strobes.
// Optional build macro SAP1_STEP_EN adds a single-step input usable while run=0.
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int NOP_SKIP = 0
) (
`ifdef SAP1_STEP_EN
    input  logic           step,
`endif
    input  logic           clk,
    input  logic           clr_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    output logic [5:0]     t_state,
    output logic           halted,
    output logic           pc_inc,
    output logic           pc_en,
    output logic           mar_ld,
    output logic           ram_en,
    output logic           ir_ld,
    output logic           ir_en,
    output logic           acc_ld,
    output logic           acc_en,
    output logic           su,
    output logic           eu,
    output logic           b_ld,
    output logic           out_ld
);

    logic [5:0] w_state;
    tstate_e    w_tstate;
    logic [3:0] w_op;
    logic       w_is_lda, w_is_add, w_is_sub, w_is_out, w_is_hlt, w_is_nop;
    logic       w_en;
    logic       w_halt_req;
    logic       w_skip;
    logic       r_halted;
    ctrl_word_t w_ctrl;
    ctrl_word_t w_out;

    assign w_op     = 4'(opcode);
    assign w_is_lda = (w_op == OP_LDA);
    assign w_is_add = (w_op == OP_ADD);
    assign w_is_sub = (w_op == OP_SUB);
    assign w_is_out = (w_op == OP_OUT);
    assign w_is_hlt = (w_op == OP_HLT);
    assign w_is_nop = ~(w_is_lda | w_is_add | w_is_sub | w_is_out | w_is_hlt);

    assign w_tstate   = onehot_to_tstate(w_state);
    assign w_halt_req = (w_tstate == T4) && w_is_hlt;
    assign w_skip     = (NOP_SKIP != 0) && (w_tstate == T4) && (w_is_out || w_is_nop);

`ifdef SAP1_STEP_EN
    logic [1:0] r_step_sync;
    logic       r_step_prev;
    logic       w_step_pulse;

    // Bring the asynchronous step button into the clock domain and keep its previous level.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_step_sync <= 2'b00;
            r_step_prev <= 1'b0;
        end else begin
            r_step_sync <= {r_step_sync[0], step};
            r_step_prev <= r_step_sync[1];
        end
    end

    assign w_step_pulse = r_step_sync[1] & ~r_step_prev;
    assign w_en         = ~r_halted & (run | w_step_pulse);
`else
    assign w_en         = ~r_halted & run;
`endif

    sap1_ring_counter u_ring (
        .clk   (clk),
        .clr_n (clr_n),
        .adv   (w_en),
        .skip  (w_skip),
        .halt  (w_halt_req),
        .state (w_state)
    );

    // Latch the halted flag when HLT completes T4; only clr_n clears it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_halted <= 1'b0;
        end else if (w_en && w_halt_req) begin
            r_halted <= 1'b1;
        end
    end

    // Decode the current T-state and opcode into the raw strobe set.
    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (w_tstate)
            T1: begin
                w_ctrl.pc_en  = 1'b1;
                w_ctrl.mar_ld = 1'b1;
            end
            T2: begin
                w_ctrl.pc_inc = 1'b1;
            end
            T3: begin
                w_ctrl.ram_en = 1'b1;
                w_ctrl.ir_ld  = 1'b1;
            end
            T4: begin
                if (w_is_lda || w_is_add || w_is_sub) begin
                    w_ctrl.ir_en  = 1'b1;
                    w_ctrl.mar_ld = 1'b1;
                end else if (w_is_out) begin
                    w_ctrl.acc_en = 1'b1;
                    w_ctrl.out_ld = 1'b1;
                end else begin
                    w_ctrl = CTRL_IDLE;
                end
            end
            T5: begin
                if (w_is_lda) begin
                    w_ctrl.ram_en = 1'b1;
                    w_ctrl.acc_ld = 1'b1;
                end else if (w_is_add || w_is_sub) begin
                    w_ctrl.ram_en = 1'b1;
                    w_ctrl.b_ld   = 1'b1;
                end else begin
                    w_ctrl = CTRL_IDLE;
                end
            end
            T6: begin
                if (w_is_add) begin
                    w_ctrl.eu     = 1'b1;
                    w_ctrl.acc_ld = 1'b1;
                end else if (w_is_sub) begin
                    w_ctrl.eu     = 1'b1;
                    w_ctrl.su     = 1'b1;
                    w_ctrl.acc_ld = 1'b1;
                end else begin
                    w_ctrl = CTRL_IDLE;
                end
            end
            default: begin
                w_ctrl = CTRL_IDLE;
            end
        endcase
    end

    // Strobes only reach the datapath in cycles where the sequencer is enabled.
    always_comb begin
        if (w_en) begin
            w_out = w_ctrl;
        end else begin
            w_out = CTRL_IDLE;
        end
    end

    assign t_state = w_state;
    assign halted  = r_halted;
    assign pc_inc  = w_out.pc_inc;
    assign pc_en   = w_out.pc_en;
    assign mar_ld  = w_out.mar_ld;
    assign ram_en  = w_out.ram_en;
    assign ir_ld   = w_out.ir_ld;
    assign ir_en   = w_out.ir_en;
    assign acc_ld  = w_out.acc_ld;
    assign acc_en  = w_out.acc_en;
    assign su      = w_out.su;
    assign eu      = w_out.eu;
    assign b_ld    = w_out.b_ld;
    assign out_ld  = w_out.out_ld;

endmodule
